// File: rtl/regfile_pkg.sv
// Shared defaults and index helpers for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DEF_WIDTH  = 64;
  localparam int unsigned DEF_DEPTH  = 32;
  localparam int unsigned DEF_NUM_RD = 2;

  function automatic int unsigned addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // The hardwired-zero register is always the topmost index.
  function automatic int unsigned xzr_idx(input int unsigned depth);
    return depth - 1;
  endfunction

  localparam int unsigned XZR_IDX = DEF_DEPTH - 1;

endpackage

// File: rtl/regfile_multiport_read_port.sv
// One read port: DEPTH:1 mux, write-first bypass compare and optional output register.
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int RD_REG   = 1,
  parameter int ZERO_TOP = 1,
  localparam int AW      = addr_w(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_rd_en,
  input  logic [AW-1:0]          i_rd_addr,
  input  logic [DEPTH*WIDTH-1:0] i_mem,
  input  logic                   i_wr_en,
  input  logic [AW-1:0]          i_wr_addr,
  input  logic [WIDTH-1:0]       i_wr_data,
  output logic [WIDTH-1:0]       o_rd_data
);

  localparam logic [AW-1:0] TOP_IDX = AW'(xzr_idx(DEPTH));

  logic             w_is_zero;
  logic [WIDTH-1:0] w_mux;
  logic [WIDTH-1:0] w_comb;

  assign w_is_zero = (ZERO_TOP != 0) && (i_rd_addr == TOP_IDX);

  always_comb begin
    w_mux = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_rd_addr == AW'(i)) w_mux = i_mem[i*WIDTH +: WIDTH];
    end
  end

  assign w_comb = w_is_zero ? '0 : w_mux;

  if (RD_REG != 0) begin : g_reg
    logic             w_hit;
    logic [WIDTH-1:0] r_rd_data;

    // i_wr_en arrives already qualified against the zero register.
    assign w_hit = i_wr_en && (i_wr_addr == i_rd_addr) && !w_is_zero;

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)      r_rd_data <= '0;
      else if (i_rd_en) r_rd_data <= w_hit ? i_wr_data : w_comb;
    end

    assign o_rd_data = r_rd_data;
  end else begin : g_comb
    logic w_unused;
    assign w_unused  = ^{i_clk, i_reset, i_rd_en, i_wr_en, i_wr_addr, i_wr_data};
    assign o_rd_data = w_comb;
  end

endmodule

// File: rtl/regfile_multiport.sv
// Multi-port register file: one write port, NUM_RD independent read ports, optional XZR.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int RD_REG   = 1,
  parameter int ZERO_TOP = 1,
  localparam int AW      = addr_w(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic [NUM_RD-1:0]       rd_en,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data
);

  localparam logic [AW-1:0] TOP_IDX = AW'(xzr_idx(DEPTH));

  logic [WIDTH-1:0]       r_mem [DEPTH];
  logic [DEPTH*WIDTH-1:0] w_mem_flat;
  logic                   w_wr_ok;

  assign w_wr_ok = wr_en && !((ZERO_TOP != 0) && (wr_addr == TOP_IDX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign w_mem_flat[g*WIDTH +: WIDTH] = r_mem[g];
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    rf_read_port #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .RD_REG  (RD_REG),
      .ZERO_TOP(ZERO_TOP)
    ) u_port (
      .i_clk    (clk),
      .i_reset  (reset),
      .i_rd_en  (rd_en[p]),
      .i_rd_addr(rd_addr[p*AW +: AW]),
      .i_mem    (w_mem_flat),
      .i_wr_en  (w_wr_ok),
      .i_wr_addr(wr_addr),
      .i_wr_data(wr_data),
      .o_rd_data(rd_data[p*WIDTH +: WIDTH])
    );
  end

endmodule

// File: doc/regfile_multiport.md
REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 The block SHALL have parameter WIDTH, 64, data bits per register.
REQ-002 The block SHALL have parameter DEPTH, 32, number of registers (power of two, >= 2).
REQ-003 The block SHALL have parameter NUM_RD, 2, number of independent read ports (1..4).
REQ-004 The block SHALL have parameter RD_REG, 1, read mode: 0 = combinational read, 1 = registered read, one-cycle latency.
REQ-005 The block SHALL have parameter ZERO_TOP, 1, when 1 register DEPTH-1 is hardwired zero (XZR).
REQ-006 The block SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-007 The block SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-008 The block SHALL have port wr_en, input, 1, write strobe.
REQ-009 The block SHALL have port wr_addr, input, log2(DEPTH), write register index.
REQ-010 The block SHALL have port wr_data, input, WIDTH, write value.
REQ-011 The block SHALL have port rd_en, input, NUM_RD, per-port read enable (RD_REG=1 only; ignored otherwise).
REQ-012 The block SHALL have port rd_addr, input, NUM_RD x log2(DEPTH), per-port read index.
REQ-013 The block SHALL have port rd_data, output, NUM_RD x WIDTH, per-port read value.

Function
REQ-014 The block SHALL write wr_data into register wr_addr on a rising clk edge when wr_en=1.
REQ-015 The block SHALL ignore writes to DEPTH-1 when ZERO_TOP=1; that register always reads 0.
REQ-016 With RD_REG=0, rd_data[p] SHALL equal the current contents of register rd_addr[p] combinationally.
REQ-017 With RD_REG=0, a read of the address being written SHALL return the old value until the write edge.
REQ-018 With RD_REG=1, rd_data[p] SHALL update on the edge where rd_en[p]=1 and hold its value while rd_en[p]=0.
REQ-019 With RD_REG=1, a same-edge write to the address read (wr_en=1, wr_addr=rd_addr[p], not zero register) SHALL forward wr_data into rd_data[p] (write-first bypass).
REQ-020 All NUM_RD ports SHALL operate independently; identical addresses on several ports SHALL return identical data.
REQ-021 Reading the zero register SHALL return 0 in both modes, including during a same-edge write to it.
REQ-022 Each port's read path SHALL be a DEPTH:1 mux replicated per bit slice, with no data-dependent latency.

Reset
REQ-023 Asserting reset SHALL immediately clear every register to 0, independent of clk.
REQ-024 Asserting reset SHALL immediately clear every registered rd_data to 0 (RD_REG=1).
REQ-025 A write whose edge coincides with asserted reset SHALL be discarded.
REQ-026 The first rising edge after reset deasserts SHALL accept writes and reads normally.

Structure
REQ-027 The package regfile_pkg SHALL hold defaults for WIDTH/DEPTH/NUM_RD, the address-width function, and the XZR index constant.
REQ-028 The read mux SHALL be one sub-module, rf_read_port, instantiated NUM_RD times; it contains the DEPTH:1 mux, the bypass compare and the optional output register.

Verification
REQ-029 The bench SHALL check reset: pulse reset mid-cycle after loading register 5 = 64'hDEAD -> rd_data of reg 5 reads 0 immediately, without a clk edge.
REQ-030 The bench SHALL check fill/readback: write reg k = k*64'h0101 for k=0..30, read all on 2 ports (RD_REG=1) -> each value appears one cycle after its rd_en.
REQ-031 The bench SHALL check the zero register: write reg 31 = 64'hFFFF_FFFF_FFFF_FFFF -> reads of 31 return 0 in the same cycle and afterwards.
REQ-032 The bench SHALL check bypass: reg 7 = 1, then same edge wr_addr=7 wr_data=2 with rd_addr[0]=7, rd_en[0]=1 -> rd_data[0]=2 next cycle (RD_REG=1); RD_REG=0 shows 1 before edge, 2 after.
REQ-033 The bench SHALL check hold: rd_en[1]=0 while reg at rd_addr[1] rewritten 3->4 -> rd_data[1] stays 3 until rd_en[1]=1.
REQ-034 The bench SHALL check parameter sweep: WIDTH=32, DEPTH=16, NUM_RD=3, ZERO_TOP=0 -> reg 15 writable; all three ports return correct data for random traffic against a reference model.
